// File: rtl/forwarding_scoreboard_if.sv
// ID-stage request and EX-side forwarding response bundle for forwarding_scoreboard.
// master = pipeline / bench side, slave = scoreboard side.
interface forwarding_scoreboard_if #(
    parameter int NUM_SRC = 2,
    parameter int REG_W   = 5,
    parameter int LAT_W   = 2,
    parameter int SEL_W   = 2
);
    logic                       id_valid;
    logic [NUM_SRC*REG_W-1:0]   id_rs;
    logic [NUM_SRC-1:0]         id_rs_used;
    logic [REG_W-1:0]           id_rd;
    logic                       id_we;
    logic [LAT_W-1:0]           id_lat;
    logic                       flush;
    logic                       stall;
    logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel;
    logic [31:0]                stall_count;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_we, id_lat, flush,
        input  stall, ex_fwd_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_we, id_lat, flush,
        output stall, ex_fwd_sel, stall_count
    );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Latency-aware forwarding scoreboard at the ID/EX boundary: tracks in-flight writers,
// raises the ID stall and registers a per-source forward select for EX.
module forwarding_scoreboard #(
    parameter int NUM_SRC        = 2,
    parameter int REG_W          = 5,
    parameter int FORWARD_STAGES = 3,
    parameter int LAT_W          = 2,
    parameter int SEL_W          = 2
) (
    input logic                    clk,
    input logic                    rst,
    forwarding_scoreboard_if.slave bus
);

    function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
        return (v == '0) ? '0 : v - LAT_W'(1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // In-flight writer records, position 0 = instruction currently in EX
    logic [FORWARD_STAGES-1:0] vld_p;
    logic [REG_W-1:0]          rd_p  [FORWARD_STAGES];
    logic [LAT_W-1:0]          rem_p [FORWARD_STAGES];

    logic [NUM_SRC*SEL_W-1:0]  sel_p1;
    logic [31:0]               cnt;

    logic [NUM_SRC-1:0]        busy;
    logic [SEL_W-1:0]          win_sel [NUM_SRC];
    logic                      stall;
    logic                      issue;
    logic                      ins_vld;

    // Scanning oldest to youngest lets the youngest match overwrite older ones
    always_comb begin
        busy = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            win_sel[k] = '0;
            for (int p = FORWARD_STAGES - 1; p >= 0; p--) begin
                if (bus.id_valid && bus.id_rs_used[k] && vld_p[p] &&
                    (rd_p[p] == bus.id_rs[k*REG_W +: REG_W]) &&
                    (bus.id_rs[k*REG_W +: REG_W] != '0)) begin
                    busy[k]    = (rem_p[p] != '0);
                    win_sel[k] = SEL_W'(p + 1);
                end
            end
        end
    end

    assign stall   = (|busy) & ~bus.flush & ~rst;
    assign issue   = bus.id_valid & ~stall & ~bus.flush;
    assign ins_vld = issue & bus.id_we & (bus.id_rd != '0);

    // ---- stage boundary: ID -> EX (control state) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            sel_p1 <= '0;
            cnt    <= '0;
        end else begin
            vld_p <= {vld_p[FORWARD_STAGES-2:0], ins_vld};
            for (int k = 0; k < NUM_SRC; k++) begin
                sel_p1[k*SEL_W +: SEL_W] <= issue ? win_sel[k] : '0;
            end
            if (stall) begin
                cnt <= sat_inc(cnt);
            end
        end
    end

    // ---- stage boundary: record payload shift, qualified by vld_p ----
    always_ff @(posedge clk) begin
        rd_p[0]  <= bus.id_rd;
        rem_p[0] <= bus.id_lat;
        for (int p = 1; p < FORWARD_STAGES; p++) begin
            rd_p[p]  <= rd_p[p-1];
            rem_p[p] <= sat_dec(rem_p[p-1]);
        end
    end

    assign bus.stall       = stall;
    assign bus.ex_fwd_sel  = sel_p1;
    assign bus.stall_count = cnt;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: reset, ALU chain, load-use, mul latency,
// youngest-wins, x0 and flush, with hand-computed stall / select / count values.
module tb_forwarding_scoreboard;
    localparam int NUM_SRC        = 2;
    localparam int REG_W          = 5;
    localparam int FORWARD_STAGES = 3;
    localparam int LAT_W          = 2;
    localparam int SEL_W          = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    forwarding_scoreboard_if #(
        .NUM_SRC(NUM_SRC), .REG_W(REG_W), .LAT_W(LAT_W), .SEL_W(SEL_W)
    ) bus ();

    forwarding_scoreboard #(
        .NUM_SRC(NUM_SRC), .REG_W(REG_W), .FORWARD_STAGES(FORWARD_STAGES),
        .LAT_W(LAT_W), .SEL_W(SEL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd, input logic we,
                         input logic [1:0] lat);
        bus.id_valid   = v;
        bus.id_rs      = {rs1, rs0};
        bus.id_rs_used = used;
        bus.id_rd      = rd;
        bus.id_we      = we;
        bus.id_lat     = lat;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk(tag, 32'(bus.stall), 32'(exp));
    endtask

    task automatic chk_sel(input string tag, input logic [3:0] exp);
        chk(tag, 32'(bus.ex_fwd_sel), 32'(exp));
    endtask

    initial begin
        rst       = 1'b1;
        bus.flush = 1'b0;
        idle();

        // reset
        tick(); tick(); #1;
        chk_stall("rst_stall", 1'b0);
        chk_sel("rst_sel", 4'b0000);
        chk("rst_count", bus.stall_count, 32'd0);

        // lw x7 then a reader while reset is asserted
        tick(); rst = 1'b0; drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1); #1;
        chk_stall("lw_issue_stall", 1'b0);
        tick(); rst = 1'b1; drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("stall_during_rst", 1'b0);
        tick(); rst = 1'b0; drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("post_rst_stall", 1'b0);
        chk_sel("post_rst_sel", 4'b0000);
        chk("post_rst_count", bus.stall_count, 32'd0);
        tick(); idle(); #1;
        chk_sel("no_stale_fwd", 4'b0000);

        // ALU chain on x5
        tick(); drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd0); #1;
        tick(); drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 2'd0); #1;
        chk_stall("alu_dep_stall", 1'b0);
        tick(); drive(1'b1, 5'd5, 5'd5, 2'b01, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("alu_dep2_stall", 1'b0);
        chk_sel("alu_sel1", 4'b0001);
        tick(); idle(); #1;
        chk_sel("alu_sel2_unused_src", 4'b0010);

        // load-use on x7, both sources
        tick(); drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1); #1;
        tick(); drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("lu_stall", 1'b1);
        tick(); drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("lu_release", 1'b0);
        chk_sel("lu_bubble_sel", 4'b0000);
        chk("lu_count", bus.stall_count, 32'd1);
        tick(); idle(); #1;
        chk_sel("lu_sel", 4'b1010);

        // mul x9 with latency 2
        tick(); drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd2); #1;
        tick(); drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("mul_stall1", 1'b1);
        tick(); drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("mul_stall2", 1'b1);
        tick(); drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("mul_release", 1'b0);
        chk("mul_count", bus.stall_count, 32'd3);
        tick(); idle(); #1;
        chk_sel("mul_sel", 4'b0011);

        // writer of x9 aged out after three independent instructions
        tick(); drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd0); #1;
        for (int i = 0; i < 3; i++) begin
            tick(); drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b0, 2'd0); #1;
        end
        tick(); drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("aged_stall", 1'b0);
        tick(); idle(); #1;
        chk_sel("aged_sel_regfile", 4'b0000);

        // youngest wins: older x4 lat 2, younger x4 lat 0
        tick(); drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 2'd2); #1;
        tick(); drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 2'd0); #1;
        tick(); drive(1'b1, 5'd0, 5'd4, 2'b10, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("young_stall", 1'b0);

        // x0 writer never forwards
        tick(); drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 2'd1); #1;
        chk_sel("young_sel", 4'b0100);
        tick(); drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("x0_stall", 1'b0);
        tick(); idle(); #1;
        chk_sel("x0_sel", 4'b0000);

        // flush during load-use stall
        tick(); drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1); #1;
        tick(); drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("fl_pre_stall", 1'b1);
        bus.flush = 1'b1; #1;
        chk_stall("fl_stall", 1'b0);
        tick(); bus.flush = 1'b0; drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 2'd0); #1;
        chk_stall("fl_next_stall", 1'b0);
        chk_sel("fl_sel", 4'b0000);
        chk("fl_count", bus.stall_count, 32'd3);
        tick(); idle(); #1;
        chk_sel("fl_next_sel", 4'b1010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
- Parametrised successor to the two-source, two-stage forwarding unit.
- Sits at the ID/EX boundary of the core. Tracks in-flight register writers in a shift window of FORWARD_STAGES positions (EX, MEM, WB, ...).
- Each writer carries a per-instruction result latency, so load-use and multi-cycle (mul/div) hazards use one mechanism.
- Produces the ID stall and a registered per-source forward select consumed by EX; also counts stall cycles.

Parameters:
- NUM_SRC, 2, number of source operands checked per instruction.
- REG_W, 5, register address width.
- FORWARD_STAGES, 3, tracked positions after ID (pos 0 = EX); pos p forwards as select p+1.
- LAT_W, 2, width of the latency field; every issued latency must be < FORWARD_STAGES.
- SEL_W, 2, select width; must satisfy 2^SEL_W > FORWARD_STAGES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NUM_SRC*REG_W  source addresses, source k at bits [k*REG_W +: REG_W]
- id_rs_used  in  NUM_SRC  source k is actually read
- id_rd  in  REG_W  destination
- id_we  in  1  instruction writes id_rd
- id_lat  in  LAT_W  cycles after EX before the result is forwardable (0 ALU, 1 load, 2+ mul/div)
- flush  in  1  kill the ID instruction (redirect from EX)
- stall  out  1  hold IF/ID, insert bubble into EX
- ex_fwd_sel  out  NUM_SRC*SEL_W  per-source select for EX: 0 = register file, s = forward from position s-1
- stall_count  out  32  saturating count of stall cycles

Behaviour:
- State:
  - FORWARD_STAGES records {valid, rd, rem[LAT_W]}.
  - ex_fwd_sel register.
  - stall_count register.
- Reset:
  - All record valids = 0, ex_fwd_sel = 0, stall_count = 0.
  - stall is forced to 0 while rst = 1.
  - Reset mid-operation discards all records; no stale forwarding afterwards.
- Match (combinational):
  - Source k matches record p when id_valid & id_rs_used[k] & valid[p] & rd[p] == rs_k & rs_k != 0.
  - With multiple matches, the youngest (lowest p) wins.
- Stall:
  - stall = 1 when any source's winning record has rem != 0, gated by ~flush & ~rst.
  - flush overrides stall.
- Shift: every cycle, unconditionally:
  - record[p+1] <= record[p] with rem decremented, saturating at 0.
  - The oldest record falls out and its value is then read from the register file.
- Insert into pos 0:
  - When id_valid & ~stall & ~flush: {id_we & (id_rd != 0), id_rd, id_lat}.
  - Otherwise a bubble (valid = 0).
- ex_fwd_sel (registered; 1-cycle latency; valid in the cycle the consumer is in EX):
  - When id_valid & ~stall & ~flush: source k gets winning p+1 (one shift older at EX time), or 0 if there is no match.
  - Sources with id_rs_used[k] = 0 get 0.
  - Otherwise all fields are 0.
- Latency rule: a producer issued with lat L stalls a dependent immediate successor for exactly L cycles. The consumer then sees select L+1.
- A match on a record at the last position yields select FORWARD_STAGES, which is legal. No match falls back to select 0.
- A same-cycle writer in ID is not a producer for itself. Consumers read only older records.
- stall_count increments by 1 each cycle stall = 1, saturating at 32'hFFFF_FFFF.

Test Plan:
- Reset: assert rst with stall conditions present -> stall = 0, ex_fwd_sel = 0, stall_count = 0. After release, no forwarding from pre-reset records.
- ALU chain: add x5 (lat 0), then add x6 uses rs1 = x5 -> no stall; next cycle ex_fwd_sel[src0] = 1. A third instruction using x5 one cycle later -> select 2.
- Load-use: lw x7 (lat 1), next instruction reads x7 on both sources -> stall = 1 for exactly 1 cycle, bubble inserted; then both selects = 2; stall_count = 1.
- Multi-cycle: mul x9 (lat 2), dependent next -> stall 2 cycles; then select 3. With FORWARD_STAGES = 3, an independent gap of 3 instructions -> select 0 (register file).
- Youngest-wins and x0: two writers to x4 back-to-back, then a reader -> select 1 (youngest). Writer to x0 followed by a reader of x0 -> select 0, no stall.
- Flush during load-use stall: flush = 1 -> stall = 0, bubble inserted, ex_fwd_sel = 0. The following instruction sees the load normally.
